// File: rtl/smolproc_pkg.sv
// smolproc_pkg: shared smolproc types, fetch FSM states and pipeline constants.
//   pc_t / instr_t   : 8-bit program address and instruction byte
//   fetch_state_e    : fetch FSM states (RUN, HALT)
//   RESET_PC         : PC loaded on reset
//   NOP_WORD         : bubble instruction byte, also used by decode to spot bubbles
package smolproc_pkg;
    typedef logic [7:0] pc_t;
    typedef logic [7:0] instr_t;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_e;
    localparam pc_t    RESET_PC = 8'h00;
    localparam instr_t NOP_WORD = 8'h00;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: stall capture register and decode-side output mux.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   load_i            : capture the live memory byte and its PC into the buffer
//   keep_i            : retain the current buffer contents (stall continues)
//   mem_data_i        : live instruction byte from memory
//   req_pc_i          : PC of the in-flight read
//   req_valid_i       : in-flight read is a real instruction
//   instr_o, pc_o     : instruction and PC presented to decode
//   valid_o           : presented instruction is real
//   hold_valid_o      : buffer currently owns the output
module fetch_hold_buf
    import smolproc_pkg::instr_t;
#(
    parameter int     PC_WIDTH = 8,
    parameter instr_t NOP_WORD = smolproc_pkg::NOP_WORD
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                keep_i,
    input  logic [7:0]          mem_data_i,
    input  logic [PC_WIDTH-1:0] req_pc_i,
    input  logic                req_valid_i,
    output logic [7:0]          instr_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                valid_o,
    output logic                hold_valid_o
);
    logic                hold_valid_q, hold_valid_d;
    logic [7:0]          hold_data_q;
    logic [PC_WIDTH-1:0] hold_pc_q;

    // Anything other than an ongoing stall or a fresh capture drops the buffer.
    assign hold_valid_d = load_i | (keep_i & hold_valid_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_pc_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            if (load_i) begin
                hold_data_q <= mem_data_i;
                hold_pc_q   <= req_pc_i;
            end
        end
    end

    assign hold_valid_o = hold_valid_q;
    assign valid_o      = hold_valid_q | req_valid_i;
    assign instr_o      = hold_valid_q ? hold_data_q : (req_valid_i ? mem_data_i : NOP_WORD);
    assign pc_o         = hold_valid_q ? hold_pc_q : req_pc_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: smolproc instruction fetch with sequential PC, branch redirect, stall hold and halt.
//   sig_clk, sig_rst_n : clock, asynchronous active-low reset
//   IF_addr_pgm        : program read address (registered PC) to memory_stage
//   ID_EX_data_pgm     : instruction byte returned one cycle after its address
//   ID_data_instr      : instruction to decode (NOP_WORD when invalid)
//   ID_addr_pc         : PC of ID_data_instr
//   ID_sig_valid       : ID_data_instr is real
//   ID_sig_stall       : decode holds the current instruction
//   ID_sig_halt        : current valid instruction is a halt
//   EX_sig_branch      : taken branch from EX, redirect to EX_addr_target
//   sig_halted         : fetch frozen until reset
module fetch_stage
    import smolproc_pkg::fetch_state_e;
    import smolproc_pkg::RUN;
    import smolproc_pkg::HALT;
#(
    parameter int                PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = smolproc_pkg::RESET_PC,
    parameter logic [7:0]        NOP_WORD = smolproc_pkg::NOP_WORD
) (
    input  logic                sig_clk,
    input  logic                sig_rst_n,
    output logic [PC_WIDTH-1:0] IF_addr_pgm,
    input  logic [7:0]          ID_EX_data_pgm,
    output logic [7:0]          ID_data_instr,
    output logic [PC_WIDTH-1:0] ID_addr_pc,
    output logic                ID_sig_valid,
    input  logic                ID_sig_stall,
    input  logic                ID_sig_halt,
    input  logic                EX_sig_branch,
    input  logic [PC_WIDTH-1:0] EX_addr_target,
    output logic                sig_halted
);
    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic                req_valid_q, req_valid_d;
    logic                hold_load, hold_keep, hold_valid;

    // Branch outranks halt (the halt is a younger, squashed instruction),
    // halt outranks stall, and stall/halt only count against a valid instruction.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        hold_load   = 1'b0;
        hold_keep   = 1'b0;
        if (state_q == RUN) begin
            if (EX_sig_branch) begin
                pc_d        = EX_addr_target;
                req_valid_d = 1'b0;
            end else if (ID_sig_valid && ID_sig_halt) begin
                state_d     = HALT;
                req_valid_d = 1'b0;
            end else if (ID_sig_valid && ID_sig_stall) begin
                // pc stays one ahead, so memory already returns the next byte on release.
                hold_keep = 1'b1;
                hold_load = !hold_valid;
            end else begin
                pc_d        = pc_q + 1'b1;
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sig_clk or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    fetch_hold_buf #(
        .PC_WIDTH (PC_WIDTH),
        .NOP_WORD (NOP_WORD)
    ) u_hold (
        .clk_i        (sig_clk),
        .rst_ni       (sig_rst_n),
        .load_i       (hold_load),
        .keep_i       (hold_keep),
        .mem_data_i   (ID_EX_data_pgm),
        .req_pc_i     (req_pc_q),
        .req_valid_i  (req_valid_q),
        .instr_o      (ID_data_instr),
        .pc_o         (ID_addr_pc),
        .valid_o      (ID_sig_valid),
        .hold_valid_o (hold_valid)
    );

    assign IF_addr_pgm = pc_q;
    assign sig_halted  = (state_q == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed check of fetch_stage against a presented-instruction model.
module tb_fetch_stage;
    import smolproc_pkg::*;

    logic       sig_clk = 1'b0;
    logic       sig_rst_n = 1'b0;
    logic [7:0] IF_addr_pgm;
    logic [7:0] ID_EX_data_pgm = 8'h00;
    logic [7:0] ID_data_instr;
    logic [7:0] ID_addr_pc;
    logic       ID_sig_valid;
    logic       ID_sig_stall = 1'b0;
    logic       ID_sig_halt = 1'b0;
    logic       EX_sig_branch = 1'b0;
    logic [7:0] EX_addr_target = 8'h00;
    logic       sig_halted;

    logic [7:0] mem [256];
    int         checks = 0;
    int         failures = 0;

    // Model: which instruction decode should see this cycle.
    bit         m_valid;
    bit         m_halted;
    pc_t        m_pc;

    always #5 sig_clk = ~sig_clk;

    always @(posedge sig_clk) ID_EX_data_pgm <= mem[IF_addr_pgm];

    fetch_stage dut (
        .sig_clk        (sig_clk),
        .sig_rst_n      (sig_rst_n),
        .IF_addr_pgm    (IF_addr_pgm),
        .ID_EX_data_pgm (ID_EX_data_pgm),
        .ID_data_instr  (ID_data_instr),
        .ID_addr_pc     (ID_addr_pc),
        .ID_sig_valid   (ID_sig_valid),
        .ID_sig_stall   (ID_sig_stall),
        .ID_sig_halt    (ID_sig_halt),
        .EX_sig_branch  (EX_sig_branch),
        .EX_addr_target (EX_addr_target),
        .sig_halted     (sig_halted)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out();
        chk("valid", 8'(ID_sig_valid), 8'(m_valid));
        chk("halted", 8'(sig_halted), 8'(m_halted));
        chk("instr", ID_data_instr, m_valid ? mem[m_pc] : NOP_WORD);
        if (m_valid) chk("pc", ID_addr_pc, m_pc);
    endtask

    // Drive one cycle of decode/EX inputs (called at a negedge), advance the model, check.
    task automatic cyc(input bit s, input bit h, input bit b, input pc_t t);
        ID_sig_stall   = s;
        ID_sig_halt    = h;
        EX_sig_branch  = b;
        EX_addr_target = t;
        if (!m_halted) begin
            if (b) begin
                m_valid = 1'b0;
                m_pc    = t;
            end else if (!m_valid) begin
                m_valid = 1'b1;
            end else if (h) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (!s) begin
                m_pc = m_pc + 8'd1;
            end
        end
        @(negedge sig_clk);
        check_out();
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 8'(ID_sig_valid), 8'd0);
        chk("rst_instr", ID_data_instr, NOP_WORD);
        chk("rst_pc", ID_addr_pc, 8'h00);
        chk("rst_addr", IF_addr_pgm, RESET_PC);
        chk("rst_halted", 8'(sig_halted), 8'd0);
    endtask

    task automatic release_reset();
        ID_sig_stall  = 1'b0;
        ID_sig_halt   = 1'b0;
        EX_sig_branch = 1'b0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_pc     = RESET_PC;
        @(negedge sig_clk);
        sig_rst_n = 1'b1;
        #1;
        check_out();
        @(negedge sig_clk);
        check_out();
        // Settle back to the negedge-aligned model: the release cycle above already advanced once.
    endtask

    task automatic do_reset();
        sig_rst_n = 1'b0;
        #1;
        check_reset_values();
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_pc     = RESET_PC;
        ID_sig_stall  = 1'b0;
        ID_sig_halt   = 1'b0;
        EX_sig_branch = 1'b0;
        @(negedge sig_clk);
        @(negedge sig_clk);
        sig_rst_n = 1'b1;
        #1;
        check_out();
        @(negedge sig_clk);
        m_valid = 1'b1;
        check_out();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        mem[8'h80] = 8'hA5;
        mem[8'hFF] = 8'h7E;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_pc     = RESET_PC;

        // Reset release: bubble, then 11,22,33,44 at 00..03 (do_reset leaves 11@00 presented).
        @(negedge sig_clk);
        do_reset();
        repeat (3) cyc(0, 0, 0, 8'h00);

        // Stall 3 cycles on 22@01, then 33@02 and 44@03.
        do_reset();
        cyc(0, 0, 0, 8'h00);
        repeat (3) cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Branch to 80 while presenting 22@01.
        do_reset();
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'h80);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Branch with stall while held, stall during bubble, then branch+stall to FF and wrap.
        do_reset();
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'h80);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 1, 8'hFF);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Branch beats halt; halt beats stall; HALT ignores branch and stall.
        do_reset();
        cyc(0, 1, 1, 8'h80);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h40);
        cyc(1, 0, 0, 8'h00);

        // Halt decoded at 03, later branch ignored, reset restarts.
        do_reset();
        repeat (3) cyc(0, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        repeat (3) cyc(0, 0, 1, 8'h80);
        cyc(1, 1, 0, 8'h00);

        // Async reset mid-stall takes effect without a clock edge.
        do_reset();
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        #2;
        do_reset();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
                     $urandom_range(0, 9) == 0, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
